// File: rtl/m_ext_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit.
// Latency: n/a (constants, state encoding and decode helpers only).
// Backpressure: n/a.
// Contents: funct3 encodings, FSM state type, signedness/divide decode helpers.
package m_ext_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/m_ext_divider.sv
// Unsigned radix-2 restoring divider core: one quotient bit per step.
// Latency: XLEN step cycles after load; last is high during the final step.
// Backpressure: none; the owner sequences load/step.
// Ports: ip_clk/ip_rst_n (sync active-low), load seeds dividend/divisor,
//        step runs one iteration, quotient/remainder are the live registers.
module m_ext_divider
    import m_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            ip_clk,
    input  logic            ip_rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    localparam int CNT_W = $clog2(XLEN);

    // quo_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] cnt_q;

    // Partial remainder is XLEN+1 bits wide only transiently (the shifted trial);
    // after a successful subtract it is always below the divisor, so XLEN bits
    // suffice for storage and the subtract can be done at XLEN bits.
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] diff;
    logic            take;

    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        take  = (trial >= {1'b0, dvsr_q});
        diff  = trial[XLEN-1:0] - dvsr_q;
    end

    always_ff @(posedge ip_clk) begin
        if (!ip_rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
            cnt_q  <= '0;
        end else if (step) begin
            rem_q  <= take ? diff : trial[XLEN-1:0];
            quo_q  <= {quo_q[XLEN-2:0], take};
            cnt_q  <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/m_ext_iter.sv
// Multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Latency: op_valid after edge XLEN+2 for iterative ops, after edge 1 for divide
//          special cases (and for multiplies when M_EXT_FAST_MUL_EN is defined).
// Backpressure: op_ready only in IDLE; result held in DONE until ip_ready.
// Ports: ip_valid/op_ready request side, op_valid/ip_ready result side,
//        ip_flush aborts, op_overflow/op_div_zero flag divide special cases.
// Config: define M_EXT_FAST_MUL_EN for single-cycle multiplies.
module m_ext_iter
    import m_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             ip_clk,
    input  logic             ip_rst_n,
    input  logic             ip_valid,
    output logic             op_ready,
    input  logic [XLEN-1:0]  ip_rs1,
    input  logic [XLEN-1:0]  ip_rs2,
    input  logic [2:0]       ip_funct_3,
    input  logic [TAG_W-1:0] ip_tag,
    input  logic             ip_flush,
    output logic             op_valid,
    input  logic             ip_ready,
    output logic [XLEN-1:0]  op_result,
    output logic [TAG_W-1:0] op_tag,
    output logic             op_overflow,
    output logic             op_div_zero,
    output logic             op_busy
);

    localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_q, state_nxt;
    logic   accept, dv_step, dv_last;

    // Request-side decode, evaluated on the raw inputs for use at the accept edge.
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            dz_in, ovf_in, fast_in;
    logic [XLEN-1:0] spec_res;

    // Captured operation context.
    logic [2:0]        f3_q;
    logic              neg_q;      // product / quotient sign
    logic              rem_neg_q;  // remainder follows the sign of rs1
    logic [XLEN-1:0]   mcand_q;
    logic [2*XLEN-1:0] prod_q;     // {high accumulator, multiplier shifting out}

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res, dv_quo, dv_rem;

    always_comb begin
        a_neg_in = rs1_signed(ip_funct_3) & ip_rs1[XLEN-1];
        b_neg_in = rs2_signed(ip_funct_3) & ip_rs2[XLEN-1];
        a_mag_in = a_neg_in ? -ip_rs1 : ip_rs1;
        b_mag_in = b_neg_in ? -ip_rs2 : ip_rs2;
        dz_in    = is_div(ip_funct_3) && (ip_rs2 == '0);
        ovf_in   = is_div(ip_funct_3) && rs1_signed(ip_funct_3) &&
                   (ip_rs1 == X_MIN) && (ip_rs2 == '1);
        // funct3[1] separates REM/REMU from DIV/DIVU within the divide group.
        if (dz_in) spec_res = ip_funct_3[1] ? ip_rs1 : '1;
        else       spec_res = ip_funct_3[1] ? '0 : ip_rs1;
    end

`ifdef M_EXT_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]   fast_res;

    // Sign-extending to 2*XLEN makes the low 2*XLEN bits of a plain product correct
    // for every signed/unsigned operand mix.
    always_comb begin
        fast_a    = {{XLEN{a_neg_in}}, ip_rs1};
        fast_b    = {{XLEN{b_neg_in}}, ip_rs2};
        fast_prod = fast_a * fast_b;
        fast_in   = !is_div(ip_funct_3);
        fast_res  = (ip_funct_3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb fast_in = 1'b0;
`endif

    // Next-state and control.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        dv_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ip_valid) begin
                    accept    = 1'b1;
                    state_nxt = (dz_in || ovf_in || fast_in) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                dv_step = 1'b1;
                if (dv_last) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: begin
                if (op_valid && ip_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (ip_flush) begin
            state_nxt = ST_IDLE;
            accept    = 1'b0;
            dv_step   = 1'b0;
        end
    end

    // Divider and shift-add multiplier share the CALC window; the divider's
    // counter paces both.
    m_ext_divider #(.XLEN(XLEN)) u_div (
        .ip_clk    (ip_clk),
        .ip_rst_n  (ip_rst_n),
        .load      (accept),
        .step      (dv_step),
        .dividend  (a_mag_in),
        .divisor   (b_mag_in),
        .quotient  (dv_quo),
        .remainder (dv_rem),
        .last      (dv_last)
    );

    always_comb begin
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_fix = neg_q ? -prod_q : prod_q;
        case (f3_q)
            F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res = neg_q ? -dv_quo : dv_quo;
            default:                       fix_res = rem_neg_q ? -dv_rem : dv_rem;
        endcase
    end

    always_ff @(posedge ip_clk) begin
        if (!ip_rst_n) begin
            state_q     <= ST_IDLE;
            op_ready    <= 1'b1;
            op_busy     <= 1'b0;
            op_valid    <= 1'b0;
            op_overflow <= 1'b0;
            op_div_zero <= 1'b0;
            op_result   <= '0;
            op_tag      <= '0;
            f3_q        <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
        end else begin
            state_q  <= state_nxt;
            op_ready <= (state_nxt == ST_IDLE);
            op_busy  <= (state_nxt != ST_IDLE);
            if (ip_flush) begin
                op_valid    <= 1'b0;
                op_overflow <= 1'b0;
                op_div_zero <= 1'b0;
            end else begin
                if (accept) begin
                    f3_q        <= ip_funct_3;
                    op_tag      <= ip_tag;
                    neg_q       <= a_neg_in ^ b_neg_in;
                    rem_neg_q   <= a_neg_in;
                    mcand_q     <= a_mag_in;
                    prod_q      <= {{XLEN{1'b0}}, b_mag_in};
                    op_overflow <= ovf_in;
                    op_div_zero <= dz_in;
                    if (dz_in || ovf_in) op_result <= spec_res;
`ifdef M_EXT_FAST_MUL_EN
                    else if (fast_in)    op_result <= fast_res;
`endif
                end
                if (state_q == ST_CALC) prod_q    <= {mul_sum, prod_q[XLEN-1:1]};
                if (state_q == ST_FIX)  op_result <= fix_res;
                // op_valid trails DONE entry by one edge and drops on consume.
                if (state_q == ST_DONE) op_valid  <= !(op_valid && ip_ready);
            end
        end
    end

endmodule

// File: tb/tb_m_ext_iter.sv
module tb_m_ext_iter;
    import m_ext_pkg::*;

    localparam int XLEN    = 32;
    localparam int TAG_W   = 5;
    localparam int DIV_LAT = XLEN + 2;
`ifdef M_EXT_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif

    logic             ip_clk_tb = 1'b0;
    logic             ip_rst_n  = 1'b0;
    logic             ip_valid  = 1'b0;
    logic             op_ready;
    logic [XLEN-1:0]  ip_rs1    = '0;
    logic [XLEN-1:0]  ip_rs2    = '0;
    logic [2:0]       ip_funct_3 = '0;
    logic [TAG_W-1:0] ip_tag    = '0;
    logic             ip_flush  = 1'b0;
    logic             op_valid;
    logic             ip_ready  = 1'b0;
    logic [XLEN-1:0]  op_result;
    logic [TAG_W-1:0] op_tag;
    logic             op_overflow;
    logic             op_div_zero;
    logic             op_busy;

    int checks = 0;
    int errors = 0;

    always #5 ip_clk_tb = ~ip_clk_tb;

    m_ext_iter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .ip_clk      (ip_clk_tb),
        .ip_rst_n    (ip_rst_n),
        .ip_valid    (ip_valid),
        .op_ready    (op_ready),
        .ip_rs1      (ip_rs1),
        .ip_rs2      (ip_rs2),
        .ip_funct_3  (ip_funct_3),
        .ip_tag      (ip_tag),
        .ip_flush    (ip_flush),
        .op_valid    (op_valid),
        .ip_ready    (ip_ready),
        .op_result   (op_result),
        .op_tag      (op_tag),
        .op_overflow (op_overflow),
        .op_div_zero (op_div_zero),
        .op_busy     (op_busy)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns #1 after the accept edge (edge 0).
    task automatic issue(input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        @(negedge ip_clk_tb);
        ip_funct_3 = f3;
        ip_rs1     = a;
        ip_rs2     = b;
        ip_tag     = tag;
        ip_valid   = 1'b1;
        @(posedge ip_clk_tb);
        #1;
        ip_valid   = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_res,
                          input int exp_lat, input logic exp_ovf, input logic exp_dz,
                          input int hold);
        int lat;
        issue(f3, a, b, tag);
        chk({name, "_ready_low"}, op_ready, 1'b0);
        lat = 0;
        while (!op_valid && lat < 200) begin
            @(posedge ip_clk_tb);
            #1;
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_result"}, op_result, exp_res);
        chk({name, "_tag"}, op_tag, tag);
        chk({name, "_overflow"}, op_overflow, exp_ovf);
        chk({name, "_div_zero"}, op_div_zero, exp_dz);
        for (int i = 0; i < hold; i++) begin
            @(posedge ip_clk_tb);
            #1;
            chk({name, "_hold_valid"}, op_valid, 1'b1);
            chk({name, "_hold_result"}, op_result, exp_res);
            chk({name, "_hold_tag"}, op_tag, tag);
            chk({name, "_hold_flags"}, {op_overflow, op_div_zero}, {exp_ovf, exp_dz});
            chk({name, "_hold_ready"}, op_ready, 1'b0);
        end
        @(negedge ip_clk_tb);
        ip_ready = 1'b1;
        @(posedge ip_clk_tb);
        #1;
        ip_ready = 1'b0;
        chk({name, "_consumed_valid"}, op_valid, 1'b0);
        chk({name, "_consumed_ready"}, op_ready, 1'b1);
    endtask

    initial begin
        int seen;

        // Reset
        repeat (2) @(posedge ip_clk_tb);
        #1;
        chk("rst_ready", op_ready, 1'b1);
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_busy", op_busy, 1'b0);
        chk("rst_result", op_result, 32'h0);
        chk("rst_tag", op_tag, 5'h0);
        chk("rst_flags", {op_overflow, op_div_zero}, 2'b00);
        @(negedge ip_clk_tb);
        ip_rst_n = 1'b1;

        // Multiplies
        run_op("mul",    F3_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, MUL_LAT, 1'b0, 1'b0, 0);
        run_op("mulhu",  F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, MUL_LAT, 1'b0, 1'b0, 0);
        run_op("mulh",   F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h00000000, MUL_LAT, 1'b0, 1'b0, 0);
        run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, MUL_LAT, 1'b0, 1'b0, 0);

        // Divides
        run_op("div",  F3_DIV,  32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, DIV_LAT, 1'b0, 1'b0, 0);
        run_op("rem",  F3_REM,  32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, DIV_LAT, 1'b0, 1'b0, 0);
        run_op("divu", F3_DIVU, 32'd100,      32'd7, 5'd7, 32'd14,       DIV_LAT, 1'b0, 1'b0, 0);

        // Special cases
        run_op("div_z",  F3_DIV,  32'h003AE27C, 32'h0, 5'd8,  32'hFFFFFFFF, 1, 1'b0, 1'b1, 0);
        run_op("rem_z",  F3_REM,  32'h003AE27C, 32'h0, 5'd9,  32'h003AE27C, 1, 1'b0, 1'b1, 0);
        run_op("div_ov", F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1, 1'b1, 1'b0, 0);
        run_op("rem_ov", F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h00000000, 1, 1'b1, 1'b0, 0);

        // Flush at edge 10 of a DIV
        issue(F3_DIV, 32'd1000, 32'd3, 5'd12);
        repeat (9) @(posedge ip_clk_tb);
        @(negedge ip_clk_tb);
        ip_flush = 1'b1;
        @(posedge ip_clk_tb);
        #1;
        ip_flush = 1'b0;
        chk("flush_ready", op_ready, 1'b1);
        chk("flush_busy", op_busy, 1'b0);
        seen = 0;
        repeat (40) begin
            @(posedge ip_clk_tb);
            #1;
            if (op_valid) seen = 1;
        end
        chk("flush_no_valid", seen, 0);
        run_op("divu_after_flush", F3_DIVU, 32'd100, 32'd7, 5'd13, 32'd14, DIV_LAT, 1'b0, 1'b0, 0);

        // Flush together with a request: nothing is accepted
        @(negedge ip_clk_tb);
        ip_funct_3 = F3_DIVU;
        ip_rs1     = 32'd5;
        ip_rs2     = 32'd0;
        ip_tag     = 5'd14;
        ip_valid   = 1'b1;
        ip_flush   = 1'b1;
        @(posedge ip_clk_tb);
        #1;
        ip_valid = 1'b0;
        ip_flush = 1'b0;
        chk("flush_vld_ready", op_ready, 1'b1);
        chk("flush_vld_busy", op_busy, 1'b0);
        seen = 0;
        repeat (3) begin
            @(posedge ip_clk_tb);
            #1;
            if (op_valid) seen = 1;
        end
        chk("flush_vld_no_valid", seen, 0);

        // Hold result under backpressure
        run_op("rem_z_hold", F3_REM, 32'h003AE27C, 32'h0, 5'd15, 32'h003AE27C, 1, 1'b0, 1'b1, 5);

        // Reset during CALC
        issue(F3_DIVU, 32'd100, 32'd7, 5'd16);
        repeat (5) @(posedge ip_clk_tb);
        @(negedge ip_clk_tb);
        ip_rst_n = 1'b0;
        @(posedge ip_clk_tb);
        #1;
        chk("midrst_valid", op_valid, 1'b0);
        chk("midrst_ready", op_ready, 1'b1);
        chk("midrst_busy", op_busy, 1'b0);
        chk("midrst_result", op_result, 32'h0);
        chk("midrst_tag", op_tag, 5'h0);
        chk("midrst_flags", {op_overflow, op_div_zero}, 2'b00);
        @(negedge ip_clk_tb);
        ip_rst_n = 1'b1;
        run_op("divu_z_after_rst", F3_DIVU, 32'd9, 32'd0, 5'd17, 32'hFFFFFFFF, 1, 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
